// File: rtl/fft_top_prod_requant.sv
// +----------------------------------------------------------------------------+
// | fft_top_prod_requant                                                       |
// | Convergent round + saturate of FFT twiddle products, 2-stage elastic pipe. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module fft_top_prod_requant #(
  parameter int PROD_WIDTH = 39,
  parameter int OUT_WIDTH  = 24,
  parameter int SHIFT      = 14
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [PROD_WIDTH-1:0] s_data,
  input  logic                  s_last,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [OUT_WIDTH-1:0]  m_data,
  output logic                  m_last,
  input  logic                  clr_ovf,
  output logic                  ovf_sticky,
  output logic [15:0]           ovf_count
);

  localparam int c_qw = PROD_WIDTH - SHIFT;
  localparam int c_rw = c_qw + 1;
  localparam logic [SHIFT-1:0]     c_half    = {1'b1, {(SHIFT-1){1'b0}}};
  localparam logic [OUT_WIDTH-1:0] c_sat_max = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  localparam logic [OUT_WIDTH-1:0] c_sat_min = {1'b1, {(OUT_WIDTH-1){1'b0}}};

  logic                  r_s1_valid;
  logic [c_rw-1:0]       r_s1_data;
  logic                  r_s1_last;

  logic                  w_advance;
  logic [c_qw-1:0]       w_floor;
  logic [SHIFT-1:0]      w_frac;
  logic                  w_round_up;
  logic [c_rw-1:0]       w_rounded;
  logic [c_rw-OUT_WIDTH:0] w_top;
  logic                  w_in_range;
  logic [OUT_WIDTH-1:0]  w_sat_data;
  logic                  w_ovf_evt;

  assign w_advance = !m_valid || m_ready;
  assign s_ready   = w_advance && !reset;

  // Arithmetic shift gives floor; ties go to the even neighbour.
  assign w_floor    = s_data[PROD_WIDTH-1:SHIFT];
  assign w_frac     = s_data[SHIFT-1:0];
  assign w_round_up = (w_frac > c_half) || ((w_frac == c_half) && w_floor[0]);
  assign w_rounded  = {w_floor[c_qw-1], w_floor} + {{(c_rw-1){1'b0}}, w_round_up};

  // In range when every bit from the output sign bit upward agrees.
  assign w_top      = r_s1_data[c_rw-1:OUT_WIDTH-1];
  assign w_in_range = (&w_top) || !(|w_top);
  assign w_sat_data = w_in_range          ? r_s1_data[OUT_WIDTH-1:0] :
                      r_s1_data[c_rw-1]   ? c_sat_min : c_sat_max;
  assign w_ovf_evt  = w_advance && r_s1_valid && !w_in_range;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1_data  <= '0;
      r_s1_last  <= 1'b0;
      m_valid    <= 1'b0;
      m_data     <= '0;
      m_last     <= 1'b0;
    end else if (w_advance) begin
      r_s1_valid <= s_valid && s_ready;
      r_s1_data  <= w_rounded;
      r_s1_last  <= s_last;
      m_valid    <= r_s1_valid;
      m_data     <= w_sat_data;
      m_last     <= r_s1_last;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_sticky <= 1'b0;
      ovf_count  <= '0;
    end else if (clr_ovf) begin
      ovf_sticky <= w_ovf_evt;
      ovf_count  <= {15'd0, w_ovf_evt};
    end else if (w_ovf_evt) begin
      ovf_sticky <= 1'b1;
      if (ovf_count != 16'hFFFF) begin
        ovf_count <= ovf_count + 16'd1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fft_top_prod_requant.sv
// +----------------------------------------------------------------------------+
// | tb_fft_top_prod_requant                                                    |
// | Scoreboard bench: directed products in, queued expectations checked out.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_fft_top_prod_requant;

  logic        clk;
  logic        reset;
  logic        s_valid;
  logic        s_ready;
  logic [38:0] s_data;
  logic        s_last;
  logic        m_valid;
  logic        m_ready;
  logic [23:0] m_data;
  logic        m_last;
  logic        clr_ovf;
  logic        ovf_sticky;
  logic [15:0] ovf_count;

  typedef struct {
    logic [23:0] d;
    logic        l;
    int          acc;
    bit          lat;
  } exp_t;

  exp_t        sb[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  logic [38:0] idle_data = 39'h20_0000_0000;
  bit          held = 0;
  logic [23:0] held_d;
  logic        held_l;
  bit          streaming;

  fft_top_prod_requant dut (
    .clk        (clk),
    .reset      (reset),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .s_last     (s_last),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_last     (m_last),
    .clr_ovf    (clr_ovf),
    .ovf_sticky (ovf_sticky),
    .ovf_count  (ovf_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [38:0] d, input logic l, input logic [23:0] e, input bit lat);
    int n = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    forever begin
      @(negedge clk);
      if (s_ready) begin
        sb.push_back('{d: e, l: l, acc: cyc, lat: lat});
        break;
      end
      n++;
      if (n > 200) begin
        n_tests++;
        n_fail++;
        $display("FAIL accept_timeout: s_ready stayed 0 for %0d cycles, expected 1", n);
        break;
      end
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_data  = idle_data;
    s_last  = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain_timeout: %0d outputs still pending, expected 0", sb.size());
      sb.delete();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state();
    check("rst_m_valid", 64'(m_valid), 64'd0);
    check("rst_m_data", 64'(m_data), 64'd0);
    check("rst_m_last", 64'(m_last), 64'd0);
    check("rst_s_ready", 64'(s_ready), 64'd0);
    check("rst_ovf_sticky", 64'(ovf_sticky), 64'd0);
    check("rst_ovf_count", 64'(ovf_count), 64'd0);
  endtask

  // Monitor: stability while stalled, then in-order compare on each transfer.
  always @(negedge clk) begin
    if (!reset) begin
      if (held) begin
        check("hold_valid", 64'(m_valid), 64'd1);
        check("hold_data", 64'(m_data), 64'(held_d));
        check("hold_last", 64'(m_last), 64'(held_l));
      end
      held   = m_valid && !m_ready;
      held_d = m_data;
      held_l = m_last;
      if (m_valid && m_ready) begin
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_out: got m_data 0x%0h, expected no output", m_data);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("m_data", 64'(m_data), 64'(e.d));
          check("m_last", 64'(m_last), 64'(e.l));
          if (e.lat) check("latency", 64'(cyc - e.acc), 64'd2);
        end
      end
    end else begin
      held = 0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [0:3] pat;
    reset   = 1'b0;
    s_valid = 1'b0;
    s_data  = idle_data;
    s_last  = 1'b0;
    m_ready = 1'b1;
    clr_ovf = 1'b0;
    #1 reset = 1'b1;
    #1 check_reset_state();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("s_ready_after_reset", 64'(s_ready), 64'd1);
    @(posedge clk);
    #1;

    // Positive ties and exact values.
    send(39'h4000, 1'b0, 24'd1, 1'b1);
    send(39'h6000, 1'b0, 24'd2, 1'b1);
    send(39'h2000, 1'b0, 24'd0, 1'b1);
    send(39'hA000, 1'b0, 24'd2, 1'b1);
    drain();
    check("ovf_count_none", 64'(ovf_count), 64'd0);
    check("ovf_sticky_none", 64'(ovf_sticky), 64'd0);

    // Negative ties and just-past-tie.
    send(-39'sh2000, 1'b0, 24'h000000, 1'b1);
    send(-39'sh6000, 1'b0, 24'hFFFFFE, 1'b1);
    send(-39'sh4001, 1'b0, 24'hFFFFFF, 1'b1);
    drain();

    // Saturation both ways.
    send(39'h20_0000_0000, 1'b0, 24'h7FFFFF, 1'b1);
    send(39'h40_0000_0000, 1'b0, 24'h800000, 1'b1);
    drain();
    check("ovf_sticky_sat", 64'(ovf_sticky), 64'd1);
    check("ovf_count_sat", 64'(ovf_count), 64'd2);

    // Clear coincident with a saturated stage-2 load, then clear alone.
    send(39'h20_0000_0000, 1'b0, 24'h7FFFFF, 1'b1);
    clr_ovf = 1'b1;
    @(posedge clk);
    #1 clr_ovf = 1'b0;
    check("clr_evt_count", 64'(ovf_count), 64'd1);
    check("clr_evt_sticky", 64'(ovf_sticky), 64'd1);
    clr_ovf = 1'b1;
    @(posedge clk);
    #1 clr_ovf = 1'b0;
    check("clr_count", 64'(ovf_count), 64'd0);
    check("clr_sticky", 64'(ovf_sticky), 64'd0);
    drain();

    // Backpressure stream, m_ready pattern 1,0,0,1.
    pat = 4'b1001;
    streaming = 1;
    fork
      begin
        for (int k = 1; k <= 8; k++) send(39'(k * 16384), k == 8, 24'(k), 1'b0);
        streaming = 0;
      end
      begin
        int ph = 0;
        while (streaming) begin
          m_ready = pat[ph];
          ph = (ph + 1) % 4;
          @(posedge clk);
          #1;
        end
      end
    join
    m_ready = 1'b1;
    drain();
    check("ovf_count_stream", 64'(ovf_count), 64'd0);

    // Reset with two samples in flight.
    send(39'h8000, 1'b0, 24'd2, 1'b1);
    send(39'hC000, 1'b0, 24'd3, 1'b1);
    check("inflight_valid", 64'(m_valid), 64'd1);
    #1 reset = 1'b1;
    #1 check_reset_state();
    sb.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("s_ready_after_reset2", 64'(s_ready), 64'd1);
    @(posedge clk);
    #1;
    send(39'h1C000, 1'b0, 24'd7, 1'b1);
    drain();
    repeat (4) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
